l15_multiline: RTL and testbench
================================

// Module: l15_multiline
// PURPOSE
//  Parametrised successor of the single-line L1.5: a private, direct-mapped, NUM_LINES-entry MESI cache
//  between one core and the shared L2. Adds a valid/ready core handshake, a registered core response and
//  per-line tag/state lookup for forwarded messages. Speaks the existing msg1 (req), msg2 (L2->L1.5) and
//  msg3 (ack/WB) protocol unchanged.
// PARAMETERS
//  NUM_LINES   4             cache lines; power of two, >=2; IDX_W = $clog2(NUM_LINES)
//  TAG_WIDTH   `TAG_WIDTH    line address width; index = tag[IDX_W-1:0]
//  DATA_WIDTH  `DATA_WIDTH   line data width
// PORTS
//  clk             in   1           clock
//  rst             in   1           synchronous, active-high reset
//  core_valid      in   1           core request valid
//  core_ready      out  1           = (fsm==IDLE && msg2_type==EMPTY && !rst); combinational
//  core_req        in   1           0 load, 1 store
//  core_tag        in   TAG_WIDTH   request line address
//  core_data       in   DATA_WIDTH  store data
//  core_resp_valid out  1           1-cycle pulse, load/store complete
//  core_resp_data  out  DATA_WIDTH  line data after the access
//  msg2_type/data/tag in MSG/DATA/TAG  message from L2
//  mesi_send       in   MESI_WIDTH  state granted with DATA_ACK
//  msg1_type/data/tag out MSG/DATA/TAG request to L2 (held until DATA_ACK)
//  msg3_type/data/tag out MSG/DATA/TAG FWDACK / WB_REQ to L2 (1-cycle pulse)
// BEHAVIOUR
//  Reset: every output 0 / EMPTY; all line states MESI_I, tags and data 0; fsm IDLE.
//  FSM: IDLE, WAIT_ACK. Request accepted when core_valid && core_ready.
//  Hit = state[idx]!=I && tag[idx]==core_tag.
//  - Load hit (S/E/M): next cycle core_resp_valid=1, data=line data; stay IDLE.
//  - Store hit E/M: line data<=core_data, state<=M, resp next cycle with core_data.
//  - Store hit S, or any miss: msg1 <= {LOAD_REQ|STORE_REQ, core_tag, core_data (store)}; latch req; ->WAIT_ACK.
//  - Miss with victim in M (tag differs): same cycle msg3 <= {WB_REQ, victim tag, victim data}, victim->I.
//    Victim in S/E is silently dropped to I.
//  - WAIT_ACK + msg2 DATA_ACK: line[idx] <= {msg2_tag, msg2_data, mesi_send}; msg1_type<=EMPTY;
//    core_resp_valid=1, data=msg2_data; ->IDLE. DATA_ACK in IDLE is ignored.
//  - NODATA_ACK: no state change.
//  Forwards (any fsm state), looked up at msg2_tag index; match = tag equal && state!=I:
//  - INV_FWD -> line I; msg3 INV_FWDACK.
//  - STORE_FWD -> line I; msg3 STORE_FWDACK, data = line data (0 if no match).
//  - LOAD_FWD -> line S if match; msg3 LOAD_FWDACK, data = line data (0 if no match).
//  msg3_tag = msg2_tag for FWDACKs.
//  Non-match: state untouched.
//  Priority: msg2 always beats core; core_ready=0 whenever msg2_type!=EMPTY.
//    A WB_REQ and a FWDACK never share a cycle, because a WB is issued only on an accept cycle.
//  Forward to the line being filled in WAIT_ACK: acked from current contents; the fill still completes.
//  msg1 stays stable while outstanding; at most one outstanding miss.
//  Reset mid-miss drops the request; no response is produced.
// STRUCTURE
//  MSG_TYPE_* and MESI_* codes and the widths stay in ccp_define.h; FSM state localparams are local.
//  Sub-module l15_line_array: NUM_LINES x {tag, data, state} regs.
//    Two combinational read ports: core index and msg2 index.
//    One write port, with priority fwd > fill > store.
// TESTING (NUM_LINES=4)
//  1. Load tag 0x5 from reset -> msg1 LOAD_REQ tag 5. DATA_ACK data 0xAA, mesi E.
//     -> resp 0xAA; reload tag 5 -> resp next cycle, no msg1.
//  2. Line 1 E, store tag 0x1 data 0x33 -> state M, resp 0x33, no msg1.
//     Then load tag 0x5 (same idx) -> msg1 LOAD_REQ tag 5 and msg3 WB_REQ tag 1 data 0x33 in the same cycle.
//  3. Line 2 S, store tag 0x2 data 0x44 -> msg1 STORE_REQ data 0x44.
//     DATA_ACK mesi M data 0x44 -> resp 0x44, state M.
//  4. Line 3 M data 0x77, LOAD_FWD tag 3 -> msg3 LOAD_FWDACK data 0x77, state S.
//     Then STORE_FWD tag 7 (idx 3, mismatch) -> STORE_FWDACK data 0, line 3 still S.
//  5. core_valid and INV_FWD in the same cycle -> core_ready=0, INV_FWDACK issued; request accepted the next cycle.
//  6. Reset asserted during WAIT_ACK -> all outputs 0, lines I. A late DATA_ACK is ignored, no resp.

Source files
------------

// File: rtl/l15_multiline_pkg.sv
// ============================================================================
// Module : l15_multiline_pkg
// Brief  : Message and MESI codes, default widths and helpers for l15_multiline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package l15_multiline_pkg;

    localparam int DEF_TAG_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int MSG_WIDTH      = 4;
    localparam int MESI_WIDTH     = 2;

    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_EMPTY        = 4'd0;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_REQ     = 4'd1;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_REQ    = 4'd2;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_DATA_ACK     = 4'd3;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_NODATA_ACK   = 4'd4;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_INV_FWD      = 4'd5;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_FWD    = 4'd6;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_FWD     = 4'd7;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_INV_FWDACK   = 4'd8;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_FWDACK = 4'd9;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_FWDACK  = 4'd10;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_WB_REQ       = 4'd11;

    localparam logic [MESI_WIDTH-1:0] MESI_I = 2'd0;
    localparam logic [MESI_WIDTH-1:0] MESI_S = 2'd1;
    localparam logic [MESI_WIDTH-1:0] MESI_E = 2'd2;
    localparam logic [MESI_WIDTH-1:0] MESI_M = 2'd3;

    function automatic logic is_fwd(input logic [MSG_WIDTH-1:0] t);
        return (t == MSG_TYPE_INV_FWD) || (t == MSG_TYPE_STORE_FWD) || (t == MSG_TYPE_LOAD_FWD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/l15_multiline_line_array.sv
// ============================================================================
// Module : l15_line_array
// Brief  : NUM_LINES x {tag, data, state} storage, two read ports, one
//          prioritised write port (forward > fill > core).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l15_line_array
    import l15_multiline_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(NUM_LINES)-1:0] i_core_idx,
    output logic [TAG_WIDTH-1:0]         o_core_tag,
    output logic [DATA_WIDTH-1:0]        o_core_data,
    output logic [MESI_WIDTH-1:0]        o_core_state,
    input  logic [$clog2(NUM_LINES)-1:0] i_fwd_idx,
    output logic [TAG_WIDTH-1:0]         o_fwd_tag,
    output logic [DATA_WIDTH-1:0]        o_fwd_data,
    output logic [MESI_WIDTH-1:0]        o_fwd_state,
    input  logic                         i_fwd_we,
    input  logic [MESI_WIDTH-1:0]        i_fwd_state,
    input  logic                         i_fill_we,
    input  logic [$clog2(NUM_LINES)-1:0] i_fill_idx,
    input  logic [TAG_WIDTH-1:0]         i_fill_tag,
    input  logic [DATA_WIDTH-1:0]        i_fill_data,
    input  logic [MESI_WIDTH-1:0]        i_fill_state,
    input  logic                         i_core_we,
    input  logic [DATA_WIDTH-1:0]        i_core_wdata,
    input  logic [MESI_WIDTH-1:0]        i_core_wstate
);

    logic [TAG_WIDTH-1:0]  r_tag   [NUM_LINES];
    logic [DATA_WIDTH-1:0] r_data  [NUM_LINES];
    logic [MESI_WIDTH-1:0] r_state [NUM_LINES];

    assign o_core_tag   = r_tag[i_core_idx];
    assign o_core_data  = r_data[i_core_idx];
    assign o_core_state = r_state[i_core_idx];
    assign o_fwd_tag    = r_tag[i_fwd_idx];
    assign o_fwd_data   = r_data[i_fwd_idx];
    assign o_fwd_state  = r_state[i_fwd_idx];

    // Forwards only touch state; fills replace the whole line; core writes keep the tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
                r_state[i] <= MESI_I;
            end
        end else if (i_fwd_we) begin
            r_state[i_fwd_idx] <= i_fwd_state;
        end else if (i_fill_we) begin
            r_tag[i_fill_idx]   <= i_fill_tag;
            r_data[i_fill_idx]  <= i_fill_data;
            r_state[i_fill_idx] <= i_fill_state;
        end else if (i_core_we) begin
            r_data[i_core_idx]  <= i_core_wdata;
            r_state[i_core_idx] <= i_core_wstate;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l15_multiline.sv
// ============================================================================
// Module : l15_multiline
// Brief  : Direct-mapped multi-line MESI L1.5 between one core and the L2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l15_multiline
    import l15_multiline_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_valid,
    output logic                  core_ready,
    input  logic                  core_req,
    input  logic [TAG_WIDTH-1:0]  core_tag,
    input  logic [DATA_WIDTH-1:0] core_data,
    output logic                  core_resp_valid,
    output logic [DATA_WIDTH-1:0] core_resp_data,
    input  logic [MSG_WIDTH-1:0]  msg2_type,
    input  logic [DATA_WIDTH-1:0] msg2_data,
    input  logic [TAG_WIDTH-1:0]  msg2_tag,
    input  logic [MESI_WIDTH-1:0] mesi_send,
    output logic [MSG_WIDTH-1:0]  msg1_type,
    output logic [DATA_WIDTH-1:0] msg1_data,
    output logic [TAG_WIDTH-1:0]  msg1_tag,
    output logic [MSG_WIDTH-1:0]  msg3_type,
    output logic [DATA_WIDTH-1:0] msg3_data,
    output logic [TAG_WIDTH-1:0]  msg3_tag
);

    localparam int IDX_W = $clog2(NUM_LINES);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } fsm_t;

    fsm_t r_fsm, w_fsm_nxt;

    logic [IDX_W-1:0]      r_idx;
    logic                  r_resp_valid, w_resp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_resp_data,  w_resp_data_nxt;
    logic [MSG_WIDTH-1:0]  r_msg1_type,  w_msg1_type_nxt;
    logic [TAG_WIDTH-1:0]  r_msg1_tag,   w_msg1_tag_nxt;
    logic [DATA_WIDTH-1:0] r_msg1_data,  w_msg1_data_nxt;
    logic [MSG_WIDTH-1:0]  r_msg3_type,  w_msg3_type_nxt;
    logic [TAG_WIDTH-1:0]  r_msg3_tag,   w_msg3_tag_nxt;
    logic [DATA_WIDTH-1:0] r_msg3_data,  w_msg3_data_nxt;

    logic [IDX_W-1:0]      w_cidx, w_fidx;
    logic [TAG_WIDTH-1:0]  w_ctag, w_ftag;
    logic [DATA_WIDTH-1:0] w_cdata, w_fdata;
    logic [MESI_WIDTH-1:0] w_cstate, w_fstate;
    logic                  w_hit, w_fmatch, w_fill, w_accept;
    logic                  w_fwd_we, w_core_we;
    logic [MESI_WIDTH-1:0] w_fwd_state, w_core_wstate;
    logic [DATA_WIDTH-1:0] w_core_wdata;

    assign w_cidx     = core_tag[IDX_W-1:0];
    assign w_fidx     = msg2_tag[IDX_W-1:0];
    assign core_ready = (r_fsm == ST_IDLE) && (msg2_type == MSG_TYPE_EMPTY) && !rst;
    assign w_accept   = core_valid && core_ready;
    assign w_hit      = (w_cstate != MESI_I) && (w_ctag == core_tag);
    assign w_fmatch   = (w_fstate != MESI_I) && (w_ftag == msg2_tag);
    assign w_fill     = (r_fsm == ST_WAIT_ACK) && (msg2_type == MSG_TYPE_DATA_ACK);

    l15_line_array #(
        .NUM_LINES  (NUM_LINES),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lines (
        .clk           (clk),
        .rst           (rst),
        .i_core_idx    (w_cidx),
        .o_core_tag    (w_ctag),
        .o_core_data   (w_cdata),
        .o_core_state  (w_cstate),
        .i_fwd_idx     (w_fidx),
        .o_fwd_tag     (w_ftag),
        .o_fwd_data    (w_fdata),
        .o_fwd_state   (w_fstate),
        .i_fwd_we      (w_fwd_we),
        .i_fwd_state   (w_fwd_state),
        .i_fill_we     (w_fill),
        .i_fill_idx    (r_idx),
        .i_fill_tag    (msg2_tag),
        .i_fill_data   (msg2_data),
        .i_fill_state  (mesi_send),
        .i_core_we     (w_core_we),
        .i_core_wdata  (w_core_wdata),
        .i_core_wstate (w_core_wstate)
    );

    always_comb begin
        w_fsm_nxt        = r_fsm;
        w_fwd_we         = 1'b0;
        w_fwd_state      = MESI_I;
        w_core_we        = 1'b0;
        w_core_wdata     = w_cdata;
        w_core_wstate    = w_cstate;
        w_resp_valid_nxt = 1'b0;
        w_resp_data_nxt  = '0;
        w_msg1_type_nxt  = r_msg1_type;
        w_msg1_tag_nxt   = r_msg1_tag;
        w_msg1_data_nxt  = r_msg1_data;
        w_msg3_type_nxt  = MSG_TYPE_EMPTY;
        w_msg3_tag_nxt   = '0;
        w_msg3_data_nxt  = '0;

        // Forwards are serviced in any FSM state from the line's current contents.
        if (is_fwd(msg2_type)) begin
            w_msg3_tag_nxt = msg2_tag;
            w_fwd_we       = w_fmatch;
            case (msg2_type)
                MSG_TYPE_INV_FWD: begin
                    w_msg3_type_nxt = MSG_TYPE_INV_FWDACK;
                end
                MSG_TYPE_STORE_FWD: begin
                    w_msg3_type_nxt = MSG_TYPE_STORE_FWDACK;
                    w_msg3_data_nxt = w_fmatch ? w_fdata : '0;
                end
                default: begin
                    w_msg3_type_nxt = MSG_TYPE_LOAD_FWDACK;
                    w_msg3_data_nxt = w_fmatch ? w_fdata : '0;
                    w_fwd_state     = MESI_S;
                end
            endcase
        end

        if (w_fill) begin
            w_msg1_type_nxt  = MSG_TYPE_EMPTY;
            w_msg1_tag_nxt   = '0;
            w_msg1_data_nxt  = '0;
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = msg2_data;
            w_fsm_nxt        = ST_IDLE;
        end

        if (w_accept) begin
            if (w_hit && !core_req) begin
                w_resp_valid_nxt = 1'b1;
                w_resp_data_nxt  = w_cdata;
            end else if (w_hit && (w_cstate == MESI_E || w_cstate == MESI_M)) begin
                w_core_we        = 1'b1;
                w_core_wdata     = core_data;
                w_core_wstate    = MESI_M;
                w_resp_valid_nxt = 1'b1;
                w_resp_data_nxt  = core_data;
            end else begin
                w_msg1_type_nxt = core_req ? MSG_TYPE_STORE_REQ : MSG_TYPE_LOAD_REQ;
                w_msg1_tag_nxt  = core_tag;
                w_msg1_data_nxt = core_req ? core_data : '0;
                w_fsm_nxt       = ST_WAIT_ACK;
                // A valid victim with a different tag is evicted; only a dirty one is written back.
                if (!w_hit && w_cstate != MESI_I) begin
                    w_core_we     = 1'b1;
                    w_core_wstate = MESI_I;
                    if (w_cstate == MESI_M) begin
                        w_msg3_type_nxt = MSG_TYPE_WB_REQ;
                        w_msg3_tag_nxt  = w_ctag;
                        w_msg3_data_nxt = w_cdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= ST_IDLE;
            r_idx        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_msg1_type  <= MSG_TYPE_EMPTY;
            r_msg1_tag   <= '0;
            r_msg1_data  <= '0;
            r_msg3_type  <= MSG_TYPE_EMPTY;
            r_msg3_tag   <= '0;
            r_msg3_data  <= '0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_msg1_type  <= w_msg1_type_nxt;
            r_msg1_tag   <= w_msg1_tag_nxt;
            r_msg1_data  <= w_msg1_data_nxt;
            r_msg3_type  <= w_msg3_type_nxt;
            r_msg3_tag   <= w_msg3_tag_nxt;
            r_msg3_data  <= w_msg3_data_nxt;
            if (w_accept) begin
                r_idx <= w_cidx;
            end
        end
    end

    assign core_resp_valid = r_resp_valid;
    assign core_resp_data  = r_resp_data;
    assign msg1_type       = r_msg1_type;
    assign msg1_tag        = r_msg1_tag;
    assign msg1_data       = r_msg1_data;
    assign msg3_type       = r_msg3_type;
    assign msg3_tag        = r_msg3_tag;
    assign msg3_data       = r_msg3_data;

endmodule

`default_nettype wire

// File: tb/tb_l15_multiline.sv
// ============================================================================
// Module : tb_l15_multiline
// Brief  : Scoreboard bench for l15_multiline against a line-level cache model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l15_multiline;
    import l15_multiline_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_valid, core_ready, core_req;
    logic [7:0] core_tag, core_data;
    logic       core_resp_valid;
    logic [7:0] core_resp_data;
    logic [3:0] msg2_type, msg1_type, msg3_type;
    logic [7:0] msg2_data, msg2_tag, msg1_data, msg1_tag, msg3_data, msg3_tag;
    logic [1:0] mesi_send;

    always #5 clk = ~clk;

    l15_multiline #(.NUM_LINES(4), .TAG_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .core_valid(core_valid), .core_ready(core_ready),
        .core_req(core_req), .core_tag(core_tag), .core_data(core_data),
        .core_resp_valid(core_resp_valid), .core_resp_data(core_resp_data),
        .msg2_type(msg2_type), .msg2_data(msg2_data), .msg2_tag(msg2_tag),
        .mesi_send(mesi_send), .msg1_type(msg1_type), .msg1_data(msg1_data),
        .msg1_tag(msg1_tag), .msg3_type(msg3_type), .msg3_data(msg3_data),
        .msg3_tag(msg3_tag)
    );

    typedef struct packed {
        logic [3:0] t;
        logic [7:0] tag;
        logic [7:0] data;
    } msg_t;

    msg_t       q1[$], q3[$];
    logic [7:0] qr[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Reference cache: four lines addressed by tag mod 4, plus one outstanding miss.
    logic [7:0] m_tag [4];
    logic [7:0] m_dat [4];
    logic [1:0] m_st  [4];
    bit         m_pend;
    bit         m_pend_st;
    logic [7:0] m_pend_tag;
    int         m_pend_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_unexp(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got unexpected %0h, expected nothing at %0t", name, act, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tag[i] = '0; m_dat[i] = '0; m_st[i] = MESI_I;
        end
        m_pend = 0;
    endtask

    task automatic cyc(input logic v, input logic r, input logic [7:0] t, input logic [7:0] d,
                       input logic [3:0] m2t, input logic [7:0] m2tag, input logic [7:0] m2d,
                       input logic [1:0] mesi);
        bit   rdy, match, hit;
        int   ix;
        msg_t e;
        core_valid = v; core_req = r; core_tag = t; core_data = d;
        msg2_type = m2t; msg2_tag = m2tag; msg2_data = m2d; mesi_send = mesi;
        #1;
        rdy = !m_pend && (m2t == MSG_TYPE_EMPTY);
        chk("core_ready", core_ready, rdy);
        if (m2t == MSG_TYPE_INV_FWD || m2t == MSG_TYPE_STORE_FWD || m2t == MSG_TYPE_LOAD_FWD) begin
            ix    = m2tag % 4;
            match = (m_st[ix] != MESI_I) && (m_tag[ix] == m2tag);
            e.tag  = m2tag;
            e.data = (match && m2t != MSG_TYPE_INV_FWD) ? m_dat[ix] : 8'h00;
            e.t    = (m2t == MSG_TYPE_INV_FWD)   ? MSG_TYPE_INV_FWDACK :
                     (m2t == MSG_TYPE_STORE_FWD) ? MSG_TYPE_STORE_FWDACK : MSG_TYPE_LOAD_FWDACK;
            if (match) m_st[ix] = (m2t == MSG_TYPE_LOAD_FWD) ? MESI_S : MESI_I;
            q3.push_back(e);
        end
        if (m2t == MSG_TYPE_DATA_ACK && m_pend) begin
            m_tag[m_pend_idx] = m2tag; m_dat[m_pend_idx] = m2d; m_st[m_pend_idx] = mesi;
            qr.push_back(m2d);
            m_pend = 0;
        end
        if (v && rdy) begin
            ix  = t % 4;
            hit = (m_st[ix] != MESI_I) && (m_tag[ix] == t);
            if (hit && !r) begin
                qr.push_back(m_dat[ix]);
            end else if (hit && m_st[ix] != MESI_S) begin
                m_dat[ix] = d; m_st[ix] = MESI_M;
                qr.push_back(d);
            end else begin
                q1.push_back('{r ? MSG_TYPE_STORE_REQ : MSG_TYPE_LOAD_REQ, t, r ? d : 8'h00});
                m_pend = 1; m_pend_st = r; m_pend_tag = t; m_pend_idx = ix;
                if (!hit && m_st[ix] != MESI_I) begin
                    if (m_st[ix] == MESI_M) q3.push_back('{MSG_TYPE_WB_REQ, m_tag[ix], m_dat[ix]});
                    m_st[ix] = MESI_I;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 8'h00, MSG_TYPE_EMPTY, 8'h00, 8'h00, MESI_I);
    endtask
    task automatic core(input logic r, input logic [7:0] t, input logic [7:0] d);
        cyc(1, r, t, d, MSG_TYPE_EMPTY, 8'h00, 8'h00, MESI_I);
    endtask
    task automatic l2(input logic [3:0] m2t, input logic [7:0] m2tag, input logic [7:0] m2d,
                      input logic [1:0] mesi);
        cyc(0, 0, 8'h00, 8'h00, m2t, m2tag, m2d, mesi);
    endtask
    task automatic ack(input logic [7:0] d, input logic [1:0] mesi);
        l2(MSG_TYPE_DATA_ACK, m_pend_tag, d, mesi);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_valid = 0; core_req = 0; core_tag = 0; core_data = 0;
        msg2_type = MSG_TYPE_EMPTY; msg2_tag = 0; msg2_data = 0; mesi_send = 0;
        #1;
        chk("ready_in_reset", core_ready, 0);
        model_reset();
        @(posedge clk); #1;
        chk("rst_resp_valid", core_resp_valid, 0);
        chk("rst_msg1", {msg1_type, msg1_tag, msg1_data}, 0);
        chk("rst_msg3", {msg3_type, msg3_tag, msg3_data}, 0);
        rst = 1'b0;
    endtask

    // Monitor: every DUT output event is matched against the oldest queued expectation.
    msg_t       mon_msg1;
    logic [3:0] mon_prev1 = MSG_TYPE_EMPTY;
    always @(negedge clk) begin
        if (core_resp_valid === 1'b1) begin
            if (qr.size() == 0) fail_unexp("resp", core_resp_data);
            else chk("resp_data", core_resp_data, qr.pop_front());
        end
        if (msg3_type !== MSG_TYPE_EMPTY) begin
            if (q3.size() == 0) fail_unexp("msg3", {msg3_type, msg3_tag, msg3_data});
            else chk("msg3", {msg3_type, msg3_tag, msg3_data}, q3.pop_front());
        end
        if (msg1_type !== MSG_TYPE_EMPTY) begin
            if (mon_prev1 === MSG_TYPE_EMPTY) begin
                if (q1.size() == 0) begin
                    fail_unexp("msg1", {msg1_type, msg1_tag, msg1_data});
                    mon_msg1 = '0;
                end else begin
                    mon_msg1 = q1.pop_front();
                end
            end
            chk("msg1", {msg1_type, msg1_tag, msg1_data}, mon_msg1);
        end
        mon_prev1 = msg1_type;
    end

    initial begin
        model_reset();
        do_reset();
        do_reset();

        // Cold load miss, fill E, then a load hit
        core(0, 8'h05, 8'h00); idle(); ack(8'hAA, MESI_E); core(0, 8'h05, 8'h00); idle();
        // Store hit on E, then conflicting load forces write-back of the dirty line
        core(0, 8'h01, 8'h00); ack(8'h11, MESI_E); core(1, 8'h01, 8'h33);
        core(0, 8'h05, 8'h00); idle(); ack(8'h55, MESI_E);
        // Store to a shared line upgrades via STORE_REQ
        core(0, 8'h02, 8'h00); ack(8'h22, MESI_S); core(1, 8'h02, 8'h44);
        idle(); ack(8'h44, MESI_M); core(0, 8'h02, 8'h00);
        // Forwards: matching LOAD_FWD downgrades, mismatching STORE_FWD returns zero
        core(0, 8'h03, 8'h00); ack(8'h70, MESI_E); core(1, 8'h03, 8'h77);
        l2(MSG_TYPE_LOAD_FWD, 8'h03, 8'h00, MESI_I);
        l2(MSG_TYPE_STORE_FWD, 8'h07, 8'h00, MESI_I);
        core(1, 8'h03, 8'h99); ack(8'h99, MESI_M);
        // Core request colliding with a forward is held off for one cycle
        cyc(1, 0, 8'h02, 8'h00, MSG_TYPE_INV_FWD, 8'h05, 8'h00, MESI_I);
        core(0, 8'h02, 8'h00);
        // Reset during a miss, then a late DATA_ACK must be ignored
        core(0, 8'h09, 8'h00); idle();
        do_reset();
        l2(MSG_TYPE_DATA_ACK, 8'h09, 8'hBB, MESI_E); idle();
        core(0, 8'h05, 8'h00); ack(8'h5A, MESI_S); idle();

        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] m2t;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if (m_pend && r < 30) begin
                cyc($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)),
                    8'($urandom), MSG_TYPE_DATA_ACK, m_pend_tag, 8'($urandom),
                    m_pend_st ? MESI_M : ($urandom_range(0, 1) ? MESI_E : MESI_S));
            end else if (r < 50) begin
                case ($urandom_range(0, 4))
                    0:       m2t = MSG_TYPE_INV_FWD;
                    1:       m2t = MSG_TYPE_STORE_FWD;
                    2:       m2t = MSG_TYPE_LOAD_FWD;
                    3:       m2t = MSG_TYPE_NODATA_ACK;
                    default: m2t = m_pend ? MSG_TYPE_NODATA_ACK : MSG_TYPE_DATA_ACK;
                endcase
                cyc($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)),
                    8'($urandom), m2t, 8'($urandom_range(0, 15)), 8'($urandom), MESI_E);
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), 8'($urandom_range(0, 15)),
                    8'($urandom), MSG_TYPE_EMPTY, 8'h00, 8'h00, MESI_I);
            end
        end
        if (m_pend) ack(8'hC3, m_pend_st ? MESI_M : MESI_E);
        idle(); idle(); idle();
        chk("resp_queue_drained", qr.size(), 0);
        chk("msg1_queue_drained", q1.size(), 0);
        chk("msg3_queue_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
